alu_mdu_control: RTL and testbench

- Parametrised successor to the EX-stage ALU control decoder.
- Decodes aluop/funct into ALU configuration and signedness, as before.
- Adds a multi-cycle multiply/divide unit with HI/LO registers, MFHI/MFLO/MTHI/MTLO decode, and an interlock stall toward the pipeline hazard logic.
- Sits in EX, beside the ALU; o_stall feeds the hazard unit.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/mdu_divider.sv | 94 +++++++++
 rtl/alu_mdu_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_mdu_control.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU/MDU control block: aluop and funct
// encodings, ALU configuration codes and the MDU state encoding.
package alu_pkg;

    localparam logic [2:0] ALUOP_MEM    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ANDI   = 3'b011;
    localparam logic [2:0] ALUOP_SLTI   = 3'b100;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    localparam logic [3:0] ALUCONF_AND = 4'd0;
    localparam logic [3:0] ALUCONF_OR  = 4'd1;
    localparam logic [3:0] ALUCONF_ADD = 4'd2;
    localparam logic [3:0] ALUCONF_SUB = 4'd3;
    localparam logic [3:0] ALUCONF_SLT = 4'd4;
    localparam logic [3:0] ALUCONF_NOR = 4'd5;
    localparam logic [3:0] ALUCONF_XOR = 4'd6;
    localparam logic [3:0] ALUCONF_SLL = 4'd7;
    localparam logic [3:0] ALUCONF_SRL = 4'd8;
    localparam logic [3:0] ALUCONF_SRA = 4'd9;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    function automatic logic is_hilo_funct(input logic [5:0] funct);
        logic hit;
        case (funct)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock. The first
// bit is produced at the start edge; o_done flags the cycle of the last step.
module mdu_divider #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_W-1:0] src_rem_s, src_quo_s, src_dvs_s, step_rem_s, step_quo_s;
    logic [DATA_W:0]   shifted_s, diff_s;
    logic              qbit_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    // One restoring step, fed from the inputs on start and from the registers otherwise
    always_comb begin
        if (i_start) begin
            src_rem_s = '0;
            src_quo_s = i_dividend;
            src_dvs_s = i_divisor;
        end else begin
            src_rem_s = rem_q;
            src_quo_s = quo_q;
            src_dvs_s = dvs_q;
        end
        shifted_s = {src_rem_s, src_quo_s[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, src_dvs_s};
        qbit_s    = (shifted_s >= {1'b0, src_dvs_s});
        if (qbit_s) begin
            step_rem_s = diff_s[DATA_W-1:0];
        end else begin
            step_rem_s = shifted_s[DATA_W-1:0];
        end
        step_quo_s = {src_quo_s[DATA_W-2:0], qbit_s};
    end

    // Step sequencing; a new start always overrides an operation in flight
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (i_start) begin
            rem_d = step_rem_s;
            quo_d = step_quo_s;
            dvs_d = i_divisor;
            cnt_d = CNT_W'(DATA_W - 2);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = step_rem_s;
            quo_d = step_quo_s;
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign o_done      = run_q & (cnt_q == '0);
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decode plus multi-cycle multiply/divide unit with HI/LO.
// Optional macro ALU_MDU_FAST_DIV0_EN: divide by zero skips the iterative phase.
module alu_mdu_control
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [2:0]        i_aluop,
    input  logic [5:0]        i_funct,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    output logic [3:0]        o_aluconf,
    output logic              o_sign,
    output logic              o_hilo_sel,
    output logic [DATA_W-1:0] o_hilo_data,
    output logic              o_busy,
    output logic              o_stall
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
`ifdef ALU_MDU_FAST_DIV0_EN
    localparam logic FAST_DIV0 = 1'b1;
`else
    localparam logic FAST_DIV0 = 1'b0;
`endif

    logic [3:0]          aluconf_s;
    logic                sign_s;
    logic                is_rtype_s, hilo_op_s, busy_s, stall_s, accept_s;
    logic                is_mfhi_s, is_mflo_s, is_div_funct_s, rt_zero_s;
    logic [DATA_W-1:0]   abs_a_s, abs_b_s;
    logic [2*DATA_W-1:0] mul_a_s, mul_b_s, prod_s;
    logic                div_start_s, div_done_s;
    logic [DATA_W-1:0]   div_quo_s, div_rem_s;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, op_a_q, op_a_d, op_b_q, op_b_d;
    logic              mul_sgn_q, mul_sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic              div0_q, div0_d, is_div_q, is_div_d;

    // ALU configuration and signedness decode
    always_comb begin
        aluconf_s = ALUCONF_ADD;
        sign_s    = 1'b1;
        case (i_aluop)
            ALUOP_MEM:    aluconf_s = ALUCONF_ADD;
            ALUOP_BRANCH: aluconf_s = ALUCONF_SUB;
            ALUOP_ANDI:   aluconf_s = ALUCONF_AND;
            ALUOP_SLTI:   aluconf_s = ALUCONF_SLT;
            ALUOP_RTYPE: begin
                case (i_funct)
                    F_ADD, F_ADDU: aluconf_s = ALUCONF_ADD;
                    F_SUB, F_SUBU: aluconf_s = ALUCONF_SUB;
                    F_AND:         aluconf_s = ALUCONF_AND;
                    F_OR:          aluconf_s = ALUCONF_OR;
                    F_XOR:         aluconf_s = ALUCONF_XOR;
                    F_NOR:         aluconf_s = ALUCONF_NOR;
                    F_SLT, F_SLTU: aluconf_s = ALUCONF_SLT;
                    F_SLL:         aluconf_s = ALUCONF_SLL;
                    F_SRL:         aluconf_s = ALUCONF_SRL;
                    F_SRA:         aluconf_s = ALUCONF_SRA;
                    default:       aluconf_s = ALUCONF_ADD;
                endcase
                case (i_funct)
                    F_ADDU, F_SUBU, F_SLTU, F_MULTU, F_DIVU: sign_s = 1'b0;
                    default:                                 sign_s = 1'b1;
                endcase
            end
            default:      aluconf_s = ALUCONF_ADD;
        endcase
    end

    assign is_rtype_s     = (i_aluop == ALUOP_RTYPE);
    assign hilo_op_s      = i_valid & is_rtype_s & is_hilo_funct(i_funct);
    assign busy_s         = (state_q != MDU_IDLE);
    assign stall_s        = hilo_op_s & busy_s;
    assign accept_s       = hilo_op_s & ~busy_s;
    assign is_mfhi_s      = accept_s & (i_funct == F_MFHI);
    assign is_mflo_s      = accept_s & (i_funct == F_MFLO);
    assign is_div_funct_s = (i_funct == F_DIV) | (i_funct == F_DIVU);
    assign rt_zero_s      = (i_rt_data == '0);
    assign div_start_s    = accept_s & is_div_funct_s & ~(FAST_DIV0 & rt_zero_s);

    // Operand magnitudes for the divider and sign-extended multiply operands
    always_comb begin
        if (sign_s & i_rs_data[DATA_W-1]) begin
            abs_a_s = -i_rs_data;
        end else begin
            abs_a_s = i_rs_data;
        end
        if (sign_s & i_rt_data[DATA_W-1]) begin
            abs_b_s = -i_rt_data;
        end else begin
            abs_b_s = i_rt_data;
        end
        mul_a_s = {{DATA_W{mul_sgn_q & op_a_q[DATA_W-1]}}, op_a_q};
        mul_b_s = {{DATA_W{mul_sgn_q & op_b_q[DATA_W-1]}}, op_b_q};
        prod_s  = mul_a_s * mul_b_s;
    end

    mdu_divider #(
        .DATA_W (DATA_W)
    ) u_divider (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (div_start_s),
        .i_dividend  (abs_a_s),
        .i_divisor   (abs_b_s),
        .o_done      (div_done_s),
        .o_quotient  (div_quo_s),
        .o_remainder (div_rem_s)
    );

    // MDU sequencing; the divider keeps its own step count, the top counts multiply latency
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        mul_sgn_d = mul_sgn_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept_s) begin
                    case (i_funct)
                        F_MULT, F_MULTU: begin
                            state_d   = MDU_MUL;
                            cnt_d     = CNT_W'(MUL_LAT - 1);
                            op_a_d    = i_rs_data;
                            op_b_d    = i_rt_data;
                            mul_sgn_d = sign_s;
                        end
                        F_DIV, F_DIVU: begin
                            op_a_d   = i_rs_data;
                            op_b_d   = i_rt_data;
                            q_neg_d  = sign_s & (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
                            r_neg_d  = sign_s & i_rs_data[DATA_W-1];
                            div0_d   = rt_zero_s;
                            is_div_d = 1'b1;
                            if (FAST_DIV0 & rt_zero_s) begin
                                state_d = MDU_DONE;
                            end else begin
                                state_d = MDU_DIV;
                            end
                        end
                        F_MTHI:  hi_d = i_rs_data;
                        F_MTLO:  lo_d = i_rs_data;
                        default: state_d = MDU_IDLE;
                    endcase
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod_s[2*DATA_W-1:DATA_W];
                    lo_d    = prod_s[DATA_W-1:0];
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MDU_DIV: begin
                if (div_done_s) begin
                    state_d = MDU_DONE;
                end else begin
                    state_d = MDU_DIV;
                end
            end
            MDU_DONE: begin
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = op_a_q;
                    end else begin
                        lo_d = q_neg_q ? -div_quo_s : div_quo_s;
                        hi_d = r_neg_q ? -div_rem_s : div_rem_s;
                    end
                end else begin
                    lo_d = lo_q;
                end
                state_d  = MDU_IDLE;
                cnt_d    = '0;
                is_div_d = 1'b0;
                div0_d   = 1'b0;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and HI/LO registers; reset discards any operation in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mul_sgn_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            mul_sgn_q <= mul_sgn_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
        end
    end

    // HI/LO read path toward the EX result mux
    always_comb begin
        if (is_mfhi_s) begin
            o_hilo_data = hi_q;
        end else if (is_mflo_s) begin
            o_hilo_data = lo_q;
        end else begin
            o_hilo_data = '0;
        end
    end

    assign o_hilo_sel = is_mfhi_s | is_mflo_s;
    assign o_aluconf  = aluconf_s;
    assign o_sign     = sign_s;
    assign o_busy     = busy_s;
    assign o_stall    = stall_s;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode table, MDU result table and
// hand-written stall/reset sequences. Honours ALU_MDU_FAST_DIV0_EN.
module tb_alu_mdu_control;
    import alu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;
`ifdef ALU_MDU_FAST_DIV0_EN
    localparam int DIV0_BUSY = 1;
`else
    localparam int DIV0_BUSY = DATA_W;
`endif

    logic              i_clk;
    logic              i_rst;
    logic              i_valid;
    logic [2:0]        i_aluop;
    logic [5:0]        i_funct;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic [3:0]        o_aluconf;
    logic              o_sign;
    logic              o_hilo_sel;
    logic [DATA_W-1:0] o_hilo_data;
    logic              o_busy;
    logic              o_stall;

    int errors = 0;
    int checks = 0;

    alu_mdu_control #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_aluop     (i_aluop),
        .i_funct     (i_funct),
        .i_rs_data   (i_rs_data),
        .i_rt_data   (i_rt_data),
        .o_aluconf   (o_aluconf),
        .o_sign      (o_sign),
        .o_hilo_sel  (o_hilo_sel),
        .o_hilo_data (o_hilo_data),
        .o_busy      (o_busy),
        .o_stall     (o_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0] op;
        logic [5:0] f;
        logic [3:0] conf;
        logic       sign;
    } dec_vec_t;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] rs;
        logic [31:0] rt;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_vec_t;

    dec_vec_t dv[$];
    mdu_vec_t mv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt);
        i_valid   = v;
        i_aluop   = op;
        i_funct   = f;
        i_rs_data = rs;
        i_rt_data = rt;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (!o_busy) break;
            n++;
        end
    endtask

    task automatic count_stall(output int n, output logic sel_seen);
        n = 0;
        sel_seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (!o_stall) break;
            n++;
            if (o_hilo_sel || (o_hilo_data != 32'h0)) sel_seen = 1'b1;
        end
    endtask

    // Issue one MDU op from IDLE, measure busy length, then read LO and HI back
    task automatic run_mdu(input int idx, input mdu_vec_t v);
        int n;
        drive(1'b1, ALUOP_RTYPE, v.f, v.rs, v.rt);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
        count_busy(n);
        check($sformatf("mdu%0d busy_cycles", idx), n, v.busy);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        sample();
        check($sformatf("mdu%0d lo", idx), {o_hilo_sel, o_stall, 30'h0} | o_hilo_data,
              {1'b1, 1'b0, 30'h0} | v.lo);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check($sformatf("mdu%0d hi", idx), o_hilo_data, v.hi);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        dv.push_back('{3'b000, 6'h00, 4'd2, 1'b1});
        dv.push_back('{3'b000, 6'h21, 4'd2, 1'b1});
        dv.push_back('{3'b001, 6'h00, 4'd3, 1'b1});
        dv.push_back('{3'b011, 6'h00, 4'd0, 1'b1});
        dv.push_back('{3'b100, 6'h2b, 4'd4, 1'b1});
        dv.push_back('{3'b101, 6'h22, 4'd2, 1'b1});
        dv.push_back('{3'b111, 6'h00, 4'd2, 1'b1});
        dv.push_back('{3'b010, 6'h20, 4'd2, 1'b1});
        dv.push_back('{3'b010, 6'h21, 4'd2, 1'b0});
        dv.push_back('{3'b010, 6'h22, 4'd3, 1'b1});
        dv.push_back('{3'b010, 6'h23, 4'd3, 1'b0});
        dv.push_back('{3'b010, 6'h24, 4'd0, 1'b1});
        dv.push_back('{3'b010, 6'h25, 4'd1, 1'b1});
        dv.push_back('{3'b010, 6'h26, 4'd6, 1'b1});
        dv.push_back('{3'b010, 6'h27, 4'd5, 1'b1});
        dv.push_back('{3'b010, 6'h2a, 4'd4, 1'b1});
        dv.push_back('{3'b010, 6'h2b, 4'd4, 1'b0});
        dv.push_back('{3'b010, 6'h00, 4'd7, 1'b1});
        dv.push_back('{3'b010, 6'h02, 4'd8, 1'b1});
        dv.push_back('{3'b010, 6'h03, 4'd9, 1'b1});
        dv.push_back('{3'b010, 6'h18, 4'd2, 1'b1});
        dv.push_back('{3'b010, 6'h19, 4'd2, 1'b0});
        dv.push_back('{3'b010, 6'h1a, 4'd2, 1'b1});
        dv.push_back('{3'b010, 6'h1b, 4'd2, 1'b0});
        dv.push_back('{3'b010, 6'h10, 4'd2, 1'b1});
        dv.push_back('{3'b010, 6'h3f, 4'd2, 1'b1});

        mv.push_back('{F_MULT,  32'hFFFFFFFD, 32'h00000007, MUL_LAT + 1, 32'hFFFFFFFF, 32'hFFFFFFEB});
        mv.push_back('{F_MULTU, 32'hFFFFFFFF, 32'h00000002, MUL_LAT + 1, 32'h00000001, 32'hFFFFFFFE});
        mv.push_back('{F_MULT,  32'h80000000, 32'h80000000, MUL_LAT + 1, 32'h40000000, 32'h00000000});
        mv.push_back('{F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT + 1, 32'h00000000, 32'h00000001});
        mv.push_back('{F_DIVU,  32'd100,      32'd7,        DATA_W,      32'h00000002, 32'h0000000E});
        mv.push_back('{F_DIV,   32'h00000007, 32'hFFFFFFFE, DATA_W,      32'h00000001, 32'hFFFFFFFD});
        mv.push_back('{F_DIV,   32'h80000000, 32'hFFFFFFFF, DATA_W,      32'h00000000, 32'h80000000});
        mv.push_back('{F_DIVU,  32'hFFFFFFFF, 32'h00010000, DATA_W,      32'h0000FFFF, 32'h0000FFFF});
        mv.push_back('{F_DIVU,  32'd5,        32'd0,        DIV0_BUSY,   32'h00000005, 32'hFFFFFFFF});
        mv.push_back('{F_DIV,   32'hFFFFFFFB, 32'd0,        DIV0_BUSY,   32'hFFFFFFFB, 32'hFFFFFFFF});

        i_rst = 1'b1;
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        i_rst = 1'b0;
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check("reset busy", o_busy, 1'b0);
        check("reset stall", o_stall, 1'b0);
        check("reset mfhi", {o_hilo_sel, 3'b000} | o_hilo_data, 32'h8);
        next_cycle();

        for (int i = 0; i < dv.size(); i++) begin
            drive(1'b0, dv[i].op, dv[i].f, 32'h0, 32'h0);
            sample();
            check($sformatf("decode%0d conf_sign", i), {o_aluconf, o_sign}, {dv[i].conf, dv[i].sign});
            next_cycle();
        end

        drive(1'b0, ALUOP_RTYPE, F_MULT, 32'd3, 32'd3);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
        sample();
        check("invalid mult no start", o_busy, 1'b0);
        next_cycle();

        for (int i = 0; i < mv.size(); i++) begin
            run_mdu(i, mv[i]);
        end

        // Dependent MFLO right behind a signed divide
        drive(1'b1, ALUOP_RTYPE, F_DIV, 32'hFFFFFFF9, 32'h00000002);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        count_stall(n, seen);
        check("div dep stall_cycles", n, DATA_W);
        check("div dep sel while stalled", seen, 1'b0);
        check("div dep mflo sel", o_hilo_sel, 1'b1);
        check("div dep mflo", o_hilo_data, 32'hFFFFFFFD);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check("div dep mfhi", o_hilo_data, 32'hFFFFFFFF);
        next_cycle();

        // Reset in the middle of a divide
        drive(1'b1, ALUOP_RTYPE, F_DIV, 32'd1000, 32'd3);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
        repeat (9) next_cycle();
        i_rst = 1'b1;
        sample();
        check("midrst busy before", o_busy, 1'b1);
        next_cycle();
        i_rst = 1'b0;
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check("midrst busy", o_busy, 1'b0);
        check("midrst stall", o_stall, 1'b0);
        check("midrst hi", o_hilo_data, 32'h0);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        sample();
        check("midrst lo", o_hilo_data, 32'h0);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MTLO, 32'h00001234, 32'h0);
        sample();
        check("mtlo stall", o_stall, 1'b0);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MTHI, 32'h0000ABCD, 32'h0);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        sample();
        check("mtlo readback", {o_stall, o_hilo_sel, 6'h0} | o_hilo_data, 32'h40 | 32'h1234);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check("mthi readback", o_hilo_data, 32'h0000ABCD);
        next_cycle();

        // Non-MDU traffic while busy, then a stalled MULT
        drive(1'b1, ALUOP_RTYPE, F_DIVU, 32'd9, 32'd3);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_ADD, 32'd1, 32'd2);
        sample();
        check("busy add", {o_busy, o_stall, o_aluconf}, {1'b1, 1'b0, 4'd2});
        next_cycle();
        drive(1'b1, ALUOP_MEM, 6'h00, 32'd1, 32'd2);
        sample();
        check("busy lw", {o_busy, o_stall, o_aluconf}, {1'b1, 1'b0, 4'd2});
        next_cycle();
        drive(1'b1, ALUOP_BRANCH, 6'h00, 32'd1, 32'd2);
        sample();
        check("busy beq", {o_busy, o_stall, o_aluconf}, {1'b1, 1'b0, 4'd3});
        next_cycle();
        drive(1'b0, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        sample();
        check("busy invalid mflo", {o_stall, o_hilo_sel}, 2'b00);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MULT, 32'd6, 32'd7);
        count_stall(n, seen);
        check("mult behind div stall_cycles", n, DATA_W - 4);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);
        count_busy(n);
        check("mult behind div busy_cycles", n, MUL_LAT + 1);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFLO, 32'h0, 32'h0);
        sample();
        check("mult behind div lo", o_hilo_data, 32'd42);
        next_cycle();
        drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
        sample();
        check("mult behind div hi", o_hilo_data, 32'd0);
        next_cycle();
        drive(1'b0, ALUOP_MEM, 6'h00, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
